// File: rtl/types_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg
// Shared CSR-unit types: CSR address, Zicsr op encoding, register index and
// data word, plus helpers used by csr_bank to decode and merge CSR ops.
// -----------------------------------------------------------------------------
package types_pkg;

    typedef logic [11:0] CsrAddrT;
    typedef logic [4:0]  r;
    typedef logic [31:0] word;

    // funct3 encoding of the Zicsr instructions
    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_op_t;

    localparam int CSR_BANK_MAX_WIDTH = 32;

    // Merged value of a CSR op applied to current value d with operand src.
    function automatic word csr_op_apply(csr_op_t op, word d, word src);
        word res;
        case (op)
            CSRRW, CSRRWI: res = src;
            CSRRS, CSRRSI: res = d | src;
            CSRRC, CSRRCI: res = d & ~src;
            default:       res = d;
        endcase
        return res;
    endfunction

    function automatic logic csr_op_is_imm(csr_op_t op);
        return op[2];
    endfunction

    // Set/clear forms with x0 / zimm==0 are pure reads.
    function automatic logic csr_op_writes(csr_op_t op, r rs1_zimm);
        logic wr;
        case (op)
            CSRRW, CSRRWI:                 wr = 1'b1;
            CSRRS, CSRRC, CSRRSI, CSRRCI:  wr = (rs1_zimm != 5'd0);
            default:                       wr = 1'b0;
        endcase
        return wr;
    endfunction

endpackage

// File: rtl/csr_bank_cell.sv
// -----------------------------------------------------------------------------
// csr_bank_cell
// One CSR of the bank: software write mask merge, hardware replace/set/clear
// with fixed priority, optional change strobe.
//
// Optional feature: CSR_BANK_WSTROBE_EN adds the registered wstrobe output.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   sw_we         software write to this register this cycle
//   sw_val        op result (unmasked) for this register
//   ext_set/clr   hardware set / clear bits
//   ext_we        hardware full replace with ext_data
//   val_q         current register value
//   val_d         next register value
//   wstrobe       (optional) one-cycle pulse after the value changed
// -----------------------------------------------------------------------------
module csr_bank_cell #(
    parameter int               Width      = 32,
    parameter logic [Width-1:0] ResetValue = '0,
    parameter logic [Width-1:0] WMask      = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sw_we,
    input  logic [Width-1:0] sw_val,
    input  logic [Width-1:0] ext_set,
    input  logic [Width-1:0] ext_clr,
    input  logic             ext_we,
    input  logic [Width-1:0] ext_data,
    output logic [Width-1:0] val_q,
    output logic [Width-1:0] val_d
`ifdef CSR_BANK_WSTROBE_EN
    ,
    output logic             wstrobe
`endif
);

    logic [Width-1:0] sw_next;

    always_comb begin
        sw_next = sw_we ? ((val_q & ~WMask) | (sw_val & WMask)) : val_q;
        // Replace wins outright; otherwise set beats any clear so a pend
        // raised in the same cycle as an ack is never lost.
        if (ext_we) begin
            val_d = ext_data;
        end else begin
            val_d = ext_set | (sw_next & ~ext_clr);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val_q <= ResetValue;
        end else begin
            val_q <= val_d;
        end
    end

`ifdef CSR_BANK_WSTROBE_EN
    logic wstrobe_d;
    logic wstrobe_q;

    always_comb begin
        wstrobe_d = (val_d != val_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wstrobe_q <= 1'b0;
        end else begin
            wstrobe_q <= wstrobe_d;
        end
    end

    assign wstrobe = wstrobe_q;
`endif

endmodule

// File: rtl/csr_bank.sv
// -----------------------------------------------------------------------------
// csr_bank
// Array of NumRegs CSRs at BaseAddr..BaseAddr+NumRegs-1. Decodes Zicsr ops,
// applies per-bit write masks and per-register read enables, and merges
// hardware set/clear/replace ports (see csr_bank_cell).
//
// Optional feature: CSR_BANK_WSTROBE_EN adds output wstrobe[NumRegs].
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   csr_enable         CSR instruction valid
//   csr_addr, csr_op   address and Zicsr op
//   rs1_zimm, rs1_data rs1 index / zimm, rs1 value
//   ext_set, ext_clr   hardware set / clear bits per register
//   ext_write_enable   hardware full replace per register, data in ext_data
//   hit                enabled access inside the bank
//   out                old value of addressed register (RdEn gated)
//   direct_out         next value of addressed register
//   illegal            write attempt to a fully read-only register
//   regs_q             all register contents
//   wstrobe            (optional) per-register change pulse
// -----------------------------------------------------------------------------
module csr_bank
    import types_pkg::*;
#(
    parameter int                             NumRegs     = 4,
    parameter int                             Width       = 32,
    parameter CsrAddrT                        BaseAddr    = CsrAddrT'(12'h300),
    parameter logic [NumRegs-1:0][Width-1:0]  ResetValues = '0,
    parameter logic [NumRegs-1:0][Width-1:0]  WMask       = '1,
    parameter logic [NumRegs-1:0]             RdEn        = '1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             csr_enable,
    input  CsrAddrT                          csr_addr,
    input  csr_op_t                          csr_op,
    input  r                                 rs1_zimm,
    input  word                              rs1_data,
    input  logic [NumRegs-1:0][Width-1:0]    ext_set,
    input  logic [NumRegs-1:0][Width-1:0]    ext_clr,
    input  logic [NumRegs-1:0]               ext_write_enable,
    input  logic [NumRegs-1:0][Width-1:0]    ext_data,
    output logic                             hit,
    output word                              out,
    output word                              direct_out,
    output logic                             illegal,
    output logic [NumRegs-1:0][Width-1:0]    regs_q
`ifdef CSR_BANK_WSTROBE_EN
    ,
    output logic [NumRegs-1:0]               wstrobe
`endif
);

    CsrAddrT                       idx;
    logic                          in_range;
    logic                          sw_wr;
    word                           src;
    word                           cur;
    word                           op_res;
    logic [Width-1:0]              sw_val;
    logic [NumRegs-1:0]            sel;
    logic [NumRegs-1:0][Width-1:0] next_val;

    // Wrapping subtraction; the >= test rejects addresses below the base.
    assign idx      = csr_addr - BaseAddr;
    assign in_range = (csr_addr >= BaseAddr) && (idx < CsrAddrT'(NumRegs));
    assign hit      = csr_enable && in_range;
    assign sw_wr    = csr_op_writes(csr_op, rs1_zimm);
    assign src      = csr_op_is_imm(csr_op) ? word'(rs1_zimm) : rs1_data;

    always_comb begin
        sel        = '0;
        cur        = '0;
        out        = '0;
        direct_out = '0;
        illegal    = 1'b0;
        for (int i = 0; i < NumRegs; i++) begin
            if (hit && (idx == CsrAddrT'(i))) begin
                sel[i]     = 1'b1;
                cur        = word'(regs_q[i]);
                out        = RdEn[i] ? word'(regs_q[i]) : '0;
                direct_out = word'(next_val[i]);
                illegal    = sw_wr && (WMask[i] == '0);
            end
        end
    end

    assign op_res = csr_op_apply(csr_op, cur, src);
    assign sw_val = op_res[Width-1:0];

    for (genvar g = 0; g < NumRegs; g++) begin : g_cell
        csr_bank_cell #(
            .Width      (Width),
            .ResetValue (ResetValues[g]),
            .WMask      (WMask[g])
        ) u_cell (
            .clk      (clk),
            .reset_n  (reset_n),
            .sw_we    (sel[g] && sw_wr),
            .sw_val   (sw_val),
            .ext_set  (ext_set[g]),
            .ext_clr  (ext_clr[g]),
            .ext_we   (ext_write_enable[g]),
            .ext_data (ext_data[g]),
            .val_q    (regs_q[g]),
            .val_d    (next_val[g])
`ifdef CSR_BANK_WSTROBE_EN
            ,
            .wstrobe  (wstrobe[g])
`endif
        );
    end

endmodule

// File: tb/tb_csr_bank.sv
module tb_csr_bank;
    import types_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             csr_enable;
    CsrAddrT          csr_addr;
    csr_op_t          csr_op;
    r                 rs1_zimm;
    word              rs1_data;
    logic [3:0][31:0] ext_set, ext_clr, ext_data;
    logic [3:0]       ext_write_enable;
    logic             hit, illegal;
    word              out, direct_out;
    logic [3:0][31:0] regs_q;
`ifdef CSR_BANK_WSTROBE_EN
    logic [3:0]       wstrobe;
    logic [0:0]       wstrobe8;
`endif

    logic             en8;
    logic [0:0][7:0]  ext8_zero;
    logic [0:0]       ext8_we;
    logic             hit8, illegal8;
    word              out8, direct8;
    logic [0:0][7:0]  regs8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csr_bank #(
        .NumRegs     (4),
        .Width       (32),
        .BaseAddr    (CsrAddrT'(12'h300)),
        .ResetValues ({32'd4, 32'd3, 32'd2, 32'd1}),
        .WMask       ({32'h0000_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}),
        .RdEn        (4'b0111)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .csr_enable       (csr_enable),
        .csr_addr         (csr_addr),
        .csr_op           (csr_op),
        .rs1_zimm         (rs1_zimm),
        .rs1_data         (rs1_data),
        .ext_set          (ext_set),
        .ext_clr          (ext_clr),
        .ext_write_enable (ext_write_enable),
        .ext_data         (ext_data),
        .hit              (hit),
        .out              (out),
        .direct_out       (direct_out),
        .illegal          (illegal),
        .regs_q           (regs_q)
`ifdef CSR_BANK_WSTROBE_EN
        ,
        .wstrobe          (wstrobe)
`endif
    );

    csr_bank #(
        .NumRegs (1),
        .Width   (8)
    ) dut8 (
        .clk              (clk),
        .reset_n          (reset_n),
        .csr_enable       (en8),
        .csr_addr         (csr_addr),
        .csr_op           (csr_op),
        .rs1_zimm         (rs1_zimm),
        .rs1_data         (rs1_data),
        .ext_set          (ext8_zero),
        .ext_clr          (ext8_zero),
        .ext_write_enable (ext8_we),
        .ext_data         (ext8_zero),
        .hit              (hit8),
        .out              (out8),
        .direct_out       (direct8),
        .illegal          (illegal8),
        .regs_q           (regs8)
`ifdef CSR_BANK_WSTROBE_EN
        ,
        .wstrobe          (wstrobe8)
`endif
    );

    typedef struct {
        logic    en;
        CsrAddrT addr;
        csr_op_t op;
        r        zimm;
        word     data;
        word     eset0;
        word     eclr0;
        logic    ewe0;
        word     edata0;
        logic    exp_hit;
        word     exp_out;
        word     exp_dout;
        logic    exp_ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic en, CsrAddrT addr, csr_op_t op, r zimm, word data,
                                word eset0, word eclr0, logic ewe0, word edata0,
                                logic exp_hit, word exp_out, word exp_dout, logic exp_ill);
        vec_t v;
        v.en = en; v.addr = addr; v.op = op; v.zimm = zimm; v.data = data;
        v.eset0 = eset0; v.eclr0 = eclr0; v.ewe0 = ewe0; v.edata0 = edata0;
        v.exp_hit = exp_hit; v.exp_out = exp_out; v.exp_dout = exp_dout; v.exp_ill = exp_ill;
        return v;
    endfunction

    task automatic check(input string name, input word act, input word exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        csr_enable       = 1'b0;
        en8              = 1'b0;
        csr_addr         = 12'h000;
        csr_op           = CSRRS;
        rs1_zimm         = 5'd0;
        rs1_data         = 32'h0;
        ext_set          = '0;
        ext_clr          = '0;
        ext_write_enable = '0;
        ext_data         = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        ext8_zero = '0;
        ext8_we   = '0;
        idle_inputs();
        reset_n = 1'b0;

        // Table: state carries over from vector to vector.
        vecs.push_back(mk(1, 12'h301, CSRRW,  5'd0,  32'hDEADBEEF, 0, 0, 0, 0, 1, 32'h2,        32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 12'h301, CSRRS,  5'd0,  32'h0000_0012, 0, 0, 0, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 12'h302, CSRRWI, 5'h1F, 32'h0,        0, 0, 0, 0, 1, 32'h3,        32'h1F,       0));
        vecs.push_back(mk(1, 12'h302, CSRRW,  5'd1,  32'hABCD1234, 0, 0, 0, 0, 1, 32'h1F,       32'h1234,     0));
        vecs.push_back(mk(1, 12'h303, CSRRW,  5'd1,  32'hFFFFFFFF, 0, 0, 0, 0, 1, 32'h0,        32'h4,        1));
        vecs.push_back(mk(1, 12'h303, CSRRC,  5'd0,  32'hFFFFFFFF, 0, 0, 0, 0, 1, 32'h0,        32'h4,        0));
        vecs.push_back(mk(1, 12'h303, CSRRSI, 5'd1,  32'h0,        0, 0, 0, 0, 1, 32'h0,        32'h4,        1));
        vecs.push_back(mk(1, 12'h2FF, CSRRW,  5'd1,  32'h77,       0, 0, 0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 12'h304, CSRRW,  5'd1,  32'h77,       0, 0, 0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(0, 12'h300, CSRRW,  5'd1,  32'h77,       0, 0, 0, 0, 0, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 12'h300, CSRRC,  5'd1,  32'h1,        0, 0, 0, 0, 1, 32'h1,        32'h0,        0));
        vecs.push_back(mk(1, 12'h300, CSRRC,  5'd1,  32'h1,        1, 2, 0, 0, 1, 32'h0,        32'h1,        0));
        vecs.push_back(mk(1, 12'h300, CSRRW,  5'd1,  32'hAA,       0, 0, 1, 32'h55, 1, 32'h1,   32'h55,       0));
        vecs.push_back(mk(1, 12'h300, CSRRS,  5'd0,  32'hFF,       0, 0, 0, 0, 1, 32'h55,       32'h55,       0));
        vecs.push_back(mk(1, 12'h300, CSRRSI, 5'h2,  32'h0,        0, 4, 0, 0, 1, 32'h55,       32'h53,       0));
        vecs.push_back(mk(1, 12'h300, CSRRCI, 5'h3,  32'h0,        0, 0, 0, 0, 1, 32'h53,       32'h50,       0));
        vecs.push_back(mk(1, 12'h300, CSRRS,  5'd0,  32'h0,        0, 0, 0, 0, 1, 32'h50,       32'h50,       0));

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst_reg0", regs_q[0], 32'd1);
        check("rst_reg1", regs_q[1], 32'd2);
        check("rst_reg2", regs_q[2], 32'd3);
        check("rst_reg3", regs_q[3], 32'd4);
        check("rst_out_idle", out, 32'h0);
        check("rst_hit_idle", word'(hit), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            csr_enable  = vecs[k].en;
            csr_addr    = vecs[k].addr;
            csr_op      = vecs[k].op;
            rs1_zimm    = vecs[k].zimm;
            rs1_data    = vecs[k].data;
            ext_set[0]  = vecs[k].eset0;
            ext_clr[0]  = vecs[k].eclr0;
            ext_write_enable[0] = vecs[k].ewe0;
            ext_data[0] = vecs[k].edata0;
            #2;
            check($sformatf("v%0d_hit", k),     word'(hit),     word'(vecs[k].exp_hit));
            check($sformatf("v%0d_out", k),     out,            vecs[k].exp_out);
            check($sformatf("v%0d_direct", k),  direct_out,     vecs[k].exp_dout);
            check($sformatf("v%0d_illegal", k), word'(illegal), word'(vecs[k].exp_ill));
        end
        @(negedge clk);
        idle_inputs();
        #2;
        check("end_reg0", regs_q[0], 32'h50);
        check("end_reg1", regs_q[1], 32'hDEADBEEF);
        check("end_reg2", regs_q[2], 32'h1234);
        check("end_reg3", regs_q[3], 32'h4);

        // Asynchronous reset mid-cycle with a write pending: no clock edge needed,
        // and the write is discarded.
        @(negedge clk);
        csr_enable = 1'b1;
        csr_addr   = 12'h301;
        csr_op     = CSRRW;
        rs1_data   = 32'h99;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_reg0", regs_q[0], 32'd1);
        check("async_rst_reg1", regs_q[1], 32'd2);
        check("async_rst_reg2", regs_q[2], 32'd3);
        @(negedge clk);
        check("rst_write_dropped", regs_q[1], 32'd2);
        idle_inputs();
        reset_n = 1'b1;

        // Width=8 instance: truncation and zero-extension
        @(negedge clk);
        en8      = 1'b1;
        csr_addr = 12'h300;
        csr_op   = CSRRW;
        rs1_zimm = 5'd1;
        rs1_data = 32'h1234;
        #2;
        check("w8_hit", word'(hit8), 32'h1);
        check("w8_out_old", out8, 32'h0);
        check("w8_direct", direct8, 32'h34);
        @(negedge clk);
        csr_op   = CSRRS;
        rs1_zimm = 5'd0;
        #2;
        check("w8_out_new", out8, 32'h0000_0034);
        check("w8_reg", word'(regs8[0]), 32'h34);
        check("w8_main_untouched", regs_q[0], 32'd1);
        @(negedge clk);
        idle_inputs();

`ifdef CSR_BANK_WSTROBE_EN
        @(negedge clk);
        csr_enable = 1'b1;
        csr_addr   = 12'h301;
        csr_op     = CSRRW;
        rs1_zimm   = 5'd1;
        rs1_data   = 32'h5;
        #2;
        check("ws_before", word'(wstrobe), 32'h0);
        @(negedge clk);
        #2;
        check("ws_change", word'(wstrobe), 32'h2);
        @(negedge clk);
        idle_inputs();
        #2;
        check("ws_same_value", word'(wstrobe), 32'h0);
        ext_set[2] = 32'h100;
        @(negedge clk);
        ext_set[2] = 32'h0;
        #2;
        check("ws_ext_set", word'(wstrobe), 32'h4);
        @(negedge clk);
        #2;
        check("ws_ext_done", word'(wstrobe), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
